// File: rtl/unary_add_pkg.sv
// Shared types and helpers for the N-input unary adder.
// popcount accepts up to POP_MAX_IN lanes; callers zero-extend narrower vectors.
package unary_add_pkg;

  localparam int unsigned POP_MAX_IN = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EMIT  = 2'd2
  } state_t;

  function automatic int unsigned popcount(input logic [POP_MAX_IN-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX_IN; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

  // Sum clamped to ceil; 32-bit arithmetic leaves headroom so nothing wraps.
  function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                          input int unsigned ceil);
    return ((a + b) > ceil) ? ceil : (a + b);
  endfunction

endpackage

// File: rtl/unary_emitter.sv
// Serialises a saturated count as a fixed OUT_MAX-cycle unary frame.
// Owns the emit counter and the dout/busy/done outputs.
module unary_emitter #(
  parameter int unsigned OUT_MAX = 26,
  parameter int unsigned CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] acc,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic             last_c
);

  logic [CNT_W-1:0] emit_cnt;
  logic             done_q;

  // Counter has passed the last bit: this enabled edge closes the frame.
  assign last_c = busy && (emit_cnt == CNT_W'(OUT_MAX));
  assign done   = done_q & en;

  always_ff @(posedge clk) begin
    if (rst) begin
      emit_cnt <= '0;
      dout     <= 1'b0;
      busy     <= 1'b0;
      done_q   <= 1'b0;
    end else if (en) begin
      done_q <= 1'b0;
      if (start) begin
        busy     <= 1'b1;
        emit_cnt <= '0;
        dout     <= 1'b0;
      end else if (busy) begin
        if (last_c) begin
          busy     <= 1'b0;
          done_q   <= 1'b1;
          dout     <= 1'b0;
          emit_cnt <= '0;
        end else begin
          dout     <= (emit_cnt < acc);
          emit_cnt <= emit_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/unary_add_n.sv
// NUM_IN-lane unary adder: accumulate serial unary lanes, then emit the saturated
// sum as one unary frame. Define UNARY_ADD_CNT_OUT_EN to also expose the binary sum.
module unary_add_n
  import unary_add_pkg::*;
#(
  parameter  int unsigned NUM_IN  = 2,
  parameter  int unsigned OUT_MAX = 26,
  localparam int unsigned CNT_W   = $clog2(OUT_MAX + 1),
  localparam int unsigned POP_W   = $clog2(NUM_IN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_IN-1:0] din,
  input  logic              read_or_write,
  output logic              dout,
  output logic              C,
  output logic              busy,
  output logic              done
`ifdef UNARY_ADD_CNT_OUT_EN
  ,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              cnt_valid
`endif
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic             start_c;
  logic             last_c;
  logic [POP_W-1:0] pop_c;
  int unsigned      sum_c;
  logic             ovf_c;
  logic [CNT_W-1:0] acc_sat_c;

  assign pop_c     = POP_W'(popcount(POP_MAX_IN'(din)));
  assign sum_c     = 32'(acc_q) + 32'(pop_c);
  assign ovf_c     = sum_c > OUT_MAX;
  assign acc_sat_c = CNT_W'(sat_add(32'(acc_q), 32'(pop_c), OUT_MAX));
  assign C         = c_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
    end
  end

  // acc is always zero in IDLE, so the IDLE->ACCUM step reuses the accumulate path.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    c_d     = c_q;
    start_c = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (read_or_write) begin
            state_d = EMIT;
            acc_d   = '0;
            c_d     = 1'b0;
            start_c = 1'b1;
          end else begin
            state_d = ACCUM;
            acc_d   = acc_sat_c;
            c_d     = ovf_c;
          end
        end
        ACCUM: begin
          if (read_or_write) begin
            state_d = EMIT;
            start_c = 1'b1;
          end else begin
            acc_d = acc_sat_c;
            c_d   = c_q | ovf_c;
          end
        end
        EMIT: begin
          if (last_c) begin
            state_d = IDLE;
            acc_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  unary_emitter #(
    .OUT_MAX (OUT_MAX),
    .CNT_W   (CNT_W)
  ) u_emitter (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .start  (start_c),
    .acc    (acc_q),
    .dout   (dout),
    .busy   (busy),
    .done   (done),
    .last_c (last_c)
  );

`ifdef UNARY_ADD_CNT_OUT_EN
  // Binary sum snapshot taken as an accumulated frame starts emitting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_o     <= '0;
      cnt_valid <= 1'b0;
    end else if (en) begin
      cnt_valid <= start_c && (state_q == ACCUM);
      if (start_c && (state_q == ACCUM)) begin
        cnt_o <= acc_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_unary_add_n.sv
// Directed bench for unary_add_n with a frame-level reference model checked every cycle.
module tb_unary_add_n;

  localparam int unsigned NUM_IN  = 2;
  localparam int unsigned OUT_MAX = 26;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [1:0] din = 2'b00;
  logic       rw  = 1'b0;
  logic       dout, C, busy, done;
`ifdef UNARY_ADD_CNT_OUT_EN
  logic [4:0] cnt_o;
  logic       cnt_valid;
`endif

  int checks = 0;
  int errors = 0;

  unary_add_n #(.NUM_IN(NUM_IN), .OUT_MAX(OUT_MAX)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .din           (din),
    .read_or_write (rw),
    .dout          (dout),
    .C             (C),
    .busy          (busy),
    .done          (done)
`ifdef UNARY_ADD_CNT_OUT_EN
    ,
    .cnt_o         (cnt_o),
    .cnt_valid     (cnt_valid)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: running unsaturated total, then a frame timer t counting
  // enabled cycles since the emit request (t=0 entry, bits at t=1..OUT_MAX).
  bit live = 0;
  bit in_frame = 0;
  bit post = 0;
  int sum = 0;
  int fsum = 0;
  int t = 0;

  always @(posedge clk) begin
    int lim;
    #1;
    if (rst) begin
      live = 1; in_frame = 0; post = 0; sum = 0; fsum = 0; t = 0;
    end else if (en) begin
      if (in_frame) begin
        t++;
        if (t == OUT_MAX + 1) begin
          in_frame = 0;
          post = 1;
        end
      end else begin
        post = 0;
        if (rw) begin
          in_frame = 1; t = 0; fsum = sum; sum = 0;
        end else begin
          sum += $countones(din);
        end
      end
    end
    if (live) begin
      lim = (fsum < OUT_MAX) ? fsum : OUT_MAX;
      chk("m_busy", int'(busy), int'(in_frame));
      chk("m_dout", int'(dout), int'(in_frame && t >= 1 && t <= lim));
      chk("m_done", int'(done), int'(post && en));
      chk("m_C", int'(C), (in_frame || post) ? int'(fsum > OUT_MAX) : int'(sum > OUT_MAX));
    end
  end

  task automatic step(input logic r, input logic e, input logic w, input logic [1:0] d);
    rst = r; en = e; rw = w; din = d;
    @(negedge clk);
  endtask

  // Runs one frame after its entry edge; counts ones on enabled cycles only.
  task automatic capture(input int stall_lo, input bit toggle, output int ones,
                         output int done_at, output int c_done, output int c_after);
    bit   seen;
    logic e, w;
    ones = 0; done_at = 0; c_done = 0; c_after = 0; seen = 0;
    for (int k = 1; k <= 60; k++) begin
      e = !(stall_lo > 0 && k >= stall_lo && k < stall_lo + 3);
      w = toggle && !seen && (k % 2 == 0);
      step(1'b0, e, w, seen ? 2'b00 : 2'b11);
      if (seen) begin
        c_after = int'(C);
        break;
      end
      if (e && dout) ones++;
      if (done) begin
        seen = 1; done_at = k; c_done = int'(C);
      end
    end
  endtask

  initial begin
    int ones, done_at, c_done, c_after;
    logic [1:0] d;

    step(1'b1, 1'b1, 1'b0, 2'b11);
    step(1'b1, 1'b1, 1'b0, 2'b11);
    chk("rst_dout", int'(dout), 0);
    chk("rst_C", int'(C), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    // 9 + 10 = 19
    for (int i = 0; i < 10; i++) begin
      d[1] = 1'b1; d[0] = (i < 9);
      step(1'b0, 1'b1, 1'b0, d);
    end
    step(1'b0, 1'b1, 1'b1, 2'b11);
    chk("entry_busy", int'(busy), 1);
    chk("entry_dout", int'(dout), 0);
`ifdef UNARY_ADD_CNT_OUT_EN
    chk("cnt_valid", int'(cnt_valid), 1);
    chk("cnt_o", int'(cnt_o), 19);
`endif
    capture(0, 1'b0, ones, done_at, c_done, c_after);
    chk("basic_ones", ones, 19);
    chk("basic_done_at", done_at, 27);
    chk("basic_C", c_done, 0);

    // 14 + 15 = 29 saturates at 26
    for (int i = 0; i < 16; i++) begin
      d[0] = (i < 9) || (i >= 11);
      d[1] = (i < 10) || (i >= 11);
      step(1'b0, 1'b1, 1'b0, d);
    end
    chk("sat_C_accum", int'(C), 1);
    step(1'b0, 1'b1, 1'b1, 2'b00);
    capture(0, 1'b0, ones, done_at, c_done, c_after);
    chk("sat_ones", ones, 26);
    chk("sat_done_at", done_at, 27);
    chk("sat_C_done", c_done, 1);
    chk("sat_C_after", c_after, 0);

    // acc=5 with a 3-cycle stall inside the ones region
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 2'b01);
    step(1'b0, 1'b1, 1'b1, 2'b00);
    capture(3, 1'b0, ones, done_at, c_done, c_after);
    chk("stall_ones", ones, 5);
    chk("stall_done_at", done_at, 30);

    // acc=7 with read_or_write toggling during the frame
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'b11);
    step(1'b0, 1'b1, 1'b0, 2'b01);
    step(1'b0, 1'b1, 1'b1, 2'b00);
    capture(0, 1'b1, ones, done_at, c_done, c_after);
    chk("toggle_ones", ones, 7);
    chk("toggle_done_at", done_at, 27);

    // acc=12, reset at frame cycle 10
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 2'b11);
    step(1'b0, 1'b1, 1'b1, 2'b00);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 2'b00);
    chk("abort_pre_dout", int'(dout), 1);
    step(1'b1, 1'b1, 1'b0, 2'b11);
    chk("abort_dout", int'(dout), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_C", int'(C), 0);

    // Emit straight from IDLE: all-zero frame
    step(1'b0, 1'b1, 1'b1, 2'b11);
    capture(0, 1'b0, ones, done_at, c_done, c_after);
    chk("zero_ones", ones, 0);
    chk("zero_done_at", done_at, 27);

    step(1'b0, 1'b1, 1'b0, 2'b00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
